// File: rtl/noc_local_ni_pkg.sv
// Shared flit layout, widths and TX state type for the local network interface.
package noc_local_ni_pkg;

    localparam int DATA_WIDTH   = 32;
    localparam int FLIT_DST     = 3;
    localparam int FLIT_SRC     = 3;
    localparam int FLIT_SEQ     = 4;
    localparam int FLIT_PAYLOAD = 22;

    localparam int DST_LSB      = 0;
    localparam int SRC_LSB      = 3;
    localparam int SEQ_LSB      = 6;
    localparam int PAYLOAD_LSB  = 10;

    // Receive entry keeps everything except dst, which is always our own address.
    localparam int RX_ENTRY_W   = FLIT_SRC + FLIT_SEQ + FLIT_PAYLOAD;

    typedef enum logic {
        TX_EMPTY = 1'b0,
        TX_HOLD  = 1'b1
    } tx_state_t;

    function automatic logic [DATA_WIDTH-1:0] build_flit(
        input logic [FLIT_DST-1:0]     dst,
        input logic [FLIT_SRC-1:0]     src,
        input logic [FLIT_SEQ-1:0]     seq,
        input logic [FLIT_PAYLOAD-1:0] payload
    );
        return {payload, seq, src, dst};
    endfunction

endpackage

// File: rtl/noc_local_ni_rx_fifo.sv
// First-word fall-through receive FIFO; a push into a full FIFO is legal when a pop
// happens in the same cycle.
module ni_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 29
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/noc_local_ni.sv
// Local network interface: one-entry TX hold register toward the router and a
// filtered RX FIFO toward the processing element, with traffic counters.
module noc_local_ni
    import noc_local_ni_pkg::*;
#(
    parameter logic [2:0] NODE_ADDR = 3'b000,
    parameter int         RX_DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pe_tx_valid,
    output logic                    pe_tx_ready,
    input  logic [FLIT_DST-1:0]     pe_tx_dst,
    input  logic [FLIT_PAYLOAD-1:0] pe_tx_payload,
    output logic [DATA_WIDTH-1:0]   noc_data_out,
    output logic                    noc_valid_out,
    input  logic                    noc_full_in,
    input  logic [DATA_WIDTH-1:0]   noc_data_in,
    input  logic                    noc_valid_in,
    output logic                    pe_rx_valid,
    input  logic                    pe_rx_ready,
    output logic [FLIT_SRC-1:0]     pe_rx_src,
    output logic [FLIT_SEQ-1:0]     pe_rx_seq,
    output logic [FLIT_PAYLOAD-1:0] pe_rx_payload,
    output logic [15:0]             tx_count,
    output logic [15:0]             rx_count,
    output logic [7:0]              drop_count,
    output logic [7:0]              misroute_count,
    output tx_state_t               tx_state
);

    // Handshakes: a transfer happens on a cycle where valid and ready are both high;
    // valid never depends on ready, and the router side has no ready (full / always-accept).
    logic                  tx_xfer;
    logic [DATA_WIDTH-1:0] hold_q;
    logic [FLIT_SEQ-1:0]   tx_seq;

    assign noc_valid_out = (tx_state == TX_HOLD) && !noc_full_in;
    assign pe_tx_ready   = (tx_state == TX_EMPTY) || noc_valid_out;
    assign tx_xfer       = pe_tx_valid && pe_tx_ready;
    assign noc_data_out  = hold_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_EMPTY;
            hold_q   <= '0;
            tx_seq   <= '0;
            tx_count <= '0;
        end else begin
            if (tx_xfer) begin
                hold_q   <= build_flit(pe_tx_dst, NODE_ADDR, tx_seq, pe_tx_payload);
                tx_seq   <= tx_seq + 4'd1;
                tx_state <= TX_HOLD;
            end else if (noc_valid_out) begin
                tx_state <= TX_EMPTY;
            end
            if (noc_valid_out) tx_count <= tx_count + 16'd1;
        end
    end

    logic                  rx_for_me;
    logic                  rx_full;
    logic                  rx_empty;
    logic                  rx_pop;
    logic                  rx_push;
    logic [RX_ENTRY_W-1:0] rx_head;
    logic [RX_ENTRY_W-1:0] rx_entry;

    assign rx_for_me = (noc_data_in[DST_LSB +: FLIT_DST] == NODE_ADDR);
    assign rx_pop    = pe_rx_valid && pe_rx_ready;
    assign rx_push   = noc_valid_in && rx_for_me && (!rx_full || rx_pop);
    assign rx_entry  = {noc_data_in[SRC_LSB +: FLIT_SRC],
                        noc_data_in[SEQ_LSB +: FLIT_SEQ],
                        noc_data_in[PAYLOAD_LSB +: FLIT_PAYLOAD]};

    // Misroute is judged before fullness, so a wrong-address flit never counts as a drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_count       <= '0;
            drop_count     <= '0;
            misroute_count <= '0;
        end else if (noc_valid_in) begin
            if (!rx_for_me) begin
                if (misroute_count != 8'hFF) misroute_count <= misroute_count + 8'd1;
            end else if (rx_push) begin
                rx_count <= rx_count + 16'd1;
            end else if (drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

    ni_rx_fifo #(
        .DEPTH (RX_DEPTH),
        .WIDTH (RX_ENTRY_W)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (rx_entry),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign pe_rx_valid = !rx_empty;
    assign {pe_rx_src, pe_rx_seq, pe_rx_payload} = rx_head;

endmodule

// File: tb/tb_noc_local_ni.sv
// Bench for noc_local_ni: directed scenarios then random traffic, all checked against
// a queue-based model of the interface behaviour.
module tb_noc_local_ni;
    import noc_local_ni_pkg::*;

    localparam logic [2:0] NODE  = 3'b000;
    localparam int         DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        pe_tx_valid;
    logic        pe_tx_ready;
    logic [2:0]  pe_tx_dst;
    logic [21:0] pe_tx_payload;
    logic [31:0] noc_data_out;
    logic        noc_valid_out;
    logic        noc_full_in;
    logic [31:0] noc_data_in;
    logic        noc_valid_in;
    logic        pe_rx_valid;
    logic        pe_rx_ready;
    logic [2:0]  pe_rx_src;
    logic [3:0]  pe_rx_seq;
    logic [21:0] pe_rx_payload;
    logic [15:0] tx_count;
    logic [15:0] rx_count;
    logic [7:0]  drop_count;
    logic [7:0]  misroute_count;
    tx_state_t   tx_state;

    noc_local_ni #(.NODE_ADDR(NODE), .RX_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .pe_tx_valid    (pe_tx_valid),
        .pe_tx_ready    (pe_tx_ready),
        .pe_tx_dst      (pe_tx_dst),
        .pe_tx_payload  (pe_tx_payload),
        .noc_data_out   (noc_data_out),
        .noc_valid_out  (noc_valid_out),
        .noc_full_in    (noc_full_in),
        .noc_data_in    (noc_data_in),
        .noc_valid_in   (noc_valid_in),
        .pe_rx_valid    (pe_rx_valid),
        .pe_rx_ready    (pe_rx_ready),
        .pe_rx_src      (pe_rx_src),
        .pe_rx_seq      (pe_rx_seq),
        .pe_rx_payload  (pe_rx_payload),
        .tx_count       (tx_count),
        .rx_count       (rx_count),
        .drop_count     (drop_count),
        .misroute_count (misroute_count),
        .tx_state       (tx_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;

    // Model: flits accepted but not yet written to the router, and messages waiting for the PE.
    logic [31:0] exp_q[$];
    logic [28:0] rx_q[$];
    logic [3:0]  m_seq;
    logic [15:0] m_tx;
    logic [15:0] m_rx;
    logic [7:0]  m_drop;
    logic [7:0]  m_mis;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        rx_q.delete();
        m_seq  = '0;
        m_tx   = '0;
        m_rx   = '0;
        m_drop = '0;
        m_mis  = '0;
    endtask

    // Check outputs against the model for the current inputs, then advance one clock.
    task automatic cycle();
        logic emit;
        logic rdy;
        logic pop;
        logic was_full;
        #1;
        emit = (exp_q.size() != 0) && !noc_full_in;
        rdy  = (exp_q.size() == 0) || emit;
        chk("noc_valid_out", noc_valid_out, emit);
        chk("pe_tx_ready", pe_tx_ready, rdy);
        chk("tx_state", tx_state, (exp_q.size() != 0) ? TX_HOLD : TX_EMPTY);
        if (exp_q.size() != 0) chk("noc_data_out", noc_data_out, exp_q[0]);
        chk("pe_rx_valid", pe_rx_valid, rx_q.size() != 0);
        if (rx_q.size() != 0) chk("pe_rx_head", {pe_rx_src, pe_rx_seq, pe_rx_payload}, rx_q[0]);
        chk("tx_count", tx_count, m_tx);
        chk("rx_count", rx_count, m_rx);
        chk("drop_count", drop_count, m_drop);
        chk("misroute_count", misroute_count, m_mis);
        if (rst) begin
            model_reset();
        end else begin
            if (emit) begin
                void'(exp_q.pop_front());
                m_tx++;
            end
            if (pe_tx_valid && rdy) begin
                exp_q.push_back({pe_tx_payload, m_seq, NODE, pe_tx_dst});
                m_seq++;
            end
            pop      = (rx_q.size() != 0) && pe_rx_ready;
            was_full = (rx_q.size() == DEPTH);
            if (pop) void'(rx_q.pop_front());
            if (noc_valid_in) begin
                if (noc_data_in[2:0] != NODE) begin
                    if (m_mis != 8'hFF) m_mis++;
                end else if (was_full && !pop) begin
                    if (m_drop != 8'hFF) m_drop++;
                end else begin
                    rx_q.push_back({noc_data_in[5:3], noc_data_in[9:6], noc_data_in[31:10]});
                    m_rx++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic inject_flit(input logic [2:0] dst);
        noc_valid_in = 1'b1;
        noc_data_in  = {22'($urandom), 4'($urandom), 3'($urandom), dst};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        pe_tx_valid   = 1'b0;
        pe_tx_dst     = '0;
        pe_tx_payload = '0;
        noc_full_in   = 1'b0;
        noc_data_in   = '0;
        noc_valid_in  = 1'b0;
        pe_rx_ready   = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        cycle();
        rst = 1'b0;
        chk("reset_hold_reg", noc_data_out, 32'h0);
        chk("reset_tx_ready", pe_tx_ready, 1'b1);

        // Single message, router not full.
        pe_tx_valid = 1'b1; pe_tx_dst = 3'd3; pe_tx_payload = 22'h3ABCD;
        cycle();
        pe_tx_valid = 1'b0;
        #1;
        chk("single_valid", noc_valid_out, 1'b1);
        chk("single_data", noc_data_out, {22'h3ABCD, 4'h0, NODE, 3'd3});
        cycle();
        chk("single_tx_count", tx_count, 16'd1);

        // Back-pressure for 5 cycles, then three back-to-back messages.
        do_reset();
        noc_full_in = 1'b1;
        pe_tx_valid = 1'b1; pe_tx_dst = 3'd1; pe_tx_payload = 22'($urandom);
        cycle();
        pe_tx_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_valid", noc_valid_out, 1'b0);
            chk("bp_ready", pe_tx_ready, 1'b0);
            cycle();
        end
        noc_full_in = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            pe_tx_valid = 1'b1; pe_tx_dst = 3'($urandom); pe_tx_payload = 22'($urandom);
            cycle();
            #1;
            chk("b2b_valid", noc_valid_out, 1'b1);
            chk("b2b_seq", {28'h0, noc_data_out[9:6]}, k);
        end
        pe_tx_valid = 1'b0;
        cycle();
        cycle();

        // Overfill the RX FIFO with the PE stalled, then drain it.
        do_reset();
        pe_rx_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            inject_flit(NODE);
            cycle();
        end
        noc_valid_in = 1'b0;
        chk("overfill_drop", drop_count, 8'd2);
        chk("overfill_rx", rx_count, 16'd4);
        pe_rx_ready = 1'b1;
        repeat (4) cycle();
        chk("drained_empty", pe_rx_valid, 1'b0);
        pe_rx_ready = 1'b0;

        // Misrouted flits, including counter saturation.
        inject_flit(3'd5);
        cycle();
        noc_valid_in = 1'b0;
        chk("misroute_one", misroute_count, 8'd1);
        chk("misroute_no_rx", pe_rx_valid, 1'b0);
        for (int i = 0; i < 259; i++) begin
            inject_flit(3'($urandom_range(1, 7)));
            cycle();
        end
        noc_valid_in = 1'b0;
        chk("misroute_sat", misroute_count, 8'd255);

        // Simultaneous pop and push while full.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            inject_flit(NODE);
            cycle();
        end
        pe_rx_ready = 1'b1;
        inject_flit(NODE);
        cycle();
        noc_valid_in = 1'b0;
        pe_rx_ready  = 1'b0;
        chk("fullpp_drop", drop_count, 8'd0);
        chk("fullpp_rx", rx_count, 16'd5);
        pe_rx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("fullpp_occupancy", pe_rx_valid, 1'b1);
            cycle();
        end
        chk("fullpp_drained", pe_rx_valid, 1'b0);
        pe_rx_ready = 1'b0;

        // Reset while a flit is held and the FIFO has two entries.
        do_reset();
        noc_full_in = 1'b1;
        pe_tx_valid = 1'b1; pe_tx_dst = 3'd6; pe_tx_payload = 22'($urandom);
        cycle();
        pe_tx_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            inject_flit(NODE);
            cycle();
        end
        noc_valid_in = 1'b0;
        do_reset();
        noc_full_in = 1'b0;
        #1;
        chk("rst_mid_valid", noc_valid_out, 1'b0);
        chk("rst_mid_rx_valid", pe_rx_valid, 1'b0);
        chk("rst_mid_counters", {tx_count, rx_count}, 32'h0);
        pe_tx_valid = 1'b1; pe_tx_dst = 3'd2; pe_tx_payload = 22'($urandom);
        cycle();
        pe_tx_valid = 1'b0;
        #1;
        chk("rst_mid_seq", {28'h0, noc_data_out[9:6]}, 32'h0);
        cycle();

        // Random traffic on both paths.
        for (int i = 0; i < 1500; i++) begin
            rst           = ($urandom_range(0, 199) == 0);
            pe_tx_valid   = ($urandom_range(0, 99) < 60);
            pe_tx_dst     = 3'($urandom);
            pe_tx_payload = 22'($urandom);
            noc_full_in   = ($urandom_range(0, 99) < 30);
            pe_rx_ready   = ($urandom_range(0, 99) < 40);
            noc_valid_in  = ($urandom_range(0, 99) < 55);
            noc_data_in   = {22'($urandom), 4'($urandom), 3'($urandom),
                             ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : NODE};
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
